everloop_driver: RTL and testbench

Frame serializer downstream of the everloop dual-port LED RAM. Reads consecutive 16-bit words from the RAM read port, starting at address 0, and shifts them out MSB-first as WS2812-style pulse-width-coded bits on the single LED data line. Each frame is followed by a latch (line-low) gap. Frames repeat for as long as the enable input is held high.

---
 rtl/everloop_pkg.sv | 21 ++
 rtl/everloop_bit_timer.sv | 23 ++
 rtl/everloop_driver.sv | 156 +++++++++++++++
 tb/tb_everloop_driver.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/everloop_pkg.sv
// Shared definitions for the everloop LED frame serializer: FSM encoding and
// default WS2812 timing at 50 MHz for the Creator ring.
package everloop_pkg;

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StFetch = 3'd1,
        StLoad  = 3'd2,
        StSend  = 3'd3,
        StLatch = 3'd4
    } state_e;

    localparam int unsigned DEF_T_BIT = 63;
    localparam int unsigned DEF_T0H   = 20;
    localparam int unsigned DEF_T1H   = 40;
    localparam int unsigned DEF_T_RST = 15000;

    // 35 LEDs x 4 bytes, two bytes per RAM word
    localparam int unsigned CREATOR_N_WORDS = 70;

endpackage

// File: rtl/everloop_bit_timer.sv
// Pulse-width coder for one WS2812 bit: line level and end-of-bit strobe
// derived from the position inside the bit period.
module everloop_bit_timer #(
    parameter int unsigned CNT_WIDTH = 6,
    parameter int unsigned T_BIT     = 63,
    parameter int unsigned T0H       = 20,
    parameter int unsigned T1H       = 40
) (
    input  logic [CNT_WIDTH-1:0] cnt,
    input  logic                 bit_val,
    output logic                 level,
    output logic                 bit_end
);

    logic [CNT_WIDTH-1:0] high_len;

    always_comb begin
        high_len = bit_val ? CNT_WIDTH'(T1H) : CNT_WIDTH'(T0H);
        level    = (cnt < high_len);
        bit_end  = (cnt == CNT_WIDTH'(T_BIT - 1));
    end

endmodule

// File: rtl/everloop_driver.sv
// Streams N_WORDS RAM words per frame MSB-first as WS2812 bits, prefetching
// the next word during bit 15 so words follow back to back, then a latch gap.
module everloop_driver
    import everloop_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 7,
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned N_WORDS    = CREATOR_N_WORDS,
    parameter int unsigned T_BIT      = DEF_T_BIT,
    parameter int unsigned T0H        = DEF_T0H,
    parameter int unsigned T1H        = DEF_T1H,
    parameter int unsigned T_RST      = DEF_T_RST
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  en,
    output logic [ADDR_WIDTH-1:0] adr_b,
    input  logic [DATA_WIDTH-1:0] dat_b,
    output logic                  led_out,
    output logic                  busy,
    output logic                  frame_done
);

    localparam int unsigned CW = $clog2(T_BIT);
    localparam int unsigned LW = $clog2(T_RST + 1);

    if (!(T0H > 0 && T0H < T1H && T1H < T_BIT && T_BIT >= 4 && T_RST >= 1 &&
          DATA_WIDTH == 16 && N_WORDS >= 1 && N_WORDS <= (1 << ADDR_WIDTH)))
    begin : gen_param_check
        $error("everloop_driver: illegal timing or size parameters");
    end

    state_e                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [3:0]            bit_q, bit_d;
    logic [ADDR_WIDTH-1:0] word_q, word_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [DATA_WIDTH-1:0] shadow_q, shadow_d;
    logic [LW-1:0]         latch_q, latch_d;
    logic [ADDR_WIDTH-1:0] adr_q, adr_d;
    logic                  led_q, led_d;
    logic                  done_q, done_d;

    logic bit_level;
    logic bit_end;

    everloop_bit_timer #(
        .CNT_WIDTH(CW),
        .T_BIT    (T_BIT),
        .T0H      (T0H),
        .T1H      (T1H)
    ) u_bit_timer (
        .cnt    (cnt_q),
        .bit_val(shift_q[DATA_WIDTH-1]),
        .level  (bit_level),
        .bit_end(bit_end)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        bit_d    = bit_q;
        word_d   = word_q;
        shift_d  = shift_q;
        shadow_d = shadow_q;
        latch_d  = latch_q;
        adr_d    = adr_q;
        led_d    = 1'b0;
        done_d   = 1'b0;

        unique case (state_q)
            StIdle: begin
                adr_d = '0;
                if (en) state_d = StFetch;
            end
            StFetch: begin
                adr_d   = '0;
                state_d = StLoad;
            end
            StLoad: begin
                shift_d = dat_b;
                bit_d   = 4'd15;
                word_d  = '0;
                cnt_d   = '0;
                state_d = StSend;
            end
            StSend: begin
                led_d = bit_level;
                // Next word is fetched while the current word's first bit is on the line
                if (bit_q == 4'd15 && cnt_q == '0) adr_d = word_q + 1'b1;
                if (bit_q == 4'd15 && cnt_q == CW'(2)) shadow_d = dat_b;
                if (bit_end) begin
                    cnt_d = '0;
                    if (bit_q == 4'd0) begin
                        if (word_q == ADDR_WIDTH'(N_WORDS - 1)) begin
                            state_d = StLatch;
                            done_d  = 1'b1;
                            latch_d = '0;
                        end else begin
                            shift_d = shadow_q;
                            word_d  = word_q + 1'b1;
                            bit_d   = 4'd15;
                        end
                    end else begin
                        shift_d = shift_q << 1;
                        bit_d   = bit_q - 4'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StLatch: begin
                adr_d = '0;
                if (latch_q == LW'(T_RST - 1)) begin
                    latch_d = '0;
                    state_d = en ? StFetch : StIdle;
                end else begin
                    latch_d = latch_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            bit_q    <= '0;
            word_q   <= '0;
            shift_q  <= '0;
            shadow_q <= '0;
            latch_q  <= '0;
            adr_q    <= '0;
            led_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            bit_q    <= bit_d;
            word_q   <= word_d;
            shift_q  <= shift_d;
            shadow_q <= shadow_d;
            latch_q  <= latch_d;
            adr_q    <= adr_d;
            led_q    <= led_d;
            done_q   <= done_d;
        end
    end

    assign adr_b      = adr_q;
    assign led_out    = led_q;
    assign frame_done = done_q;
    assign busy       = (state_q != StIdle);

endmodule

// File: tb/tb_everloop_driver.sv
// Directed bench: small-timing DUT against a 1-clock RAM model, plus a
// default-parameter DUT streaming one all-zero frame alongside.
module tb_everloop_driver;

    logic        clk;
    logic        resetn;
    logic        en;
    logic [6:0]  adr_b;
    logic [15:0] dat_b;
    logic        led_out;
    logic        busy;
    logic        frame_done;

    logic        resetn2;
    logic        en2;
    logic [6:0]  adr2;
    logic [15:0] dat2;
    logic        led2;
    logic        busy2;
    logic        frame_done2;

    logic [15:0] ram [0:127];

    int n_checks = 0;
    int n_pass   = 0;

    int cyc = 0;
    logic led_prev = 1'b0;
    int rise_t = 0;
    int rises[$];
    int widths[$];
    int fd_count = 0;

    logic led2_prev = 1'b0;
    int rise2_t = 0;
    int rises2 = 0;
    int bad2 = 0;
    int late2 = 0;
    int fd2_lbl = 0;
    int idle2_lbl = 0;

    everloop_driver #(
        .ADDR_WIDTH(7),
        .DATA_WIDTH(16),
        .N_WORDS   (2),
        .T_BIT     (10),
        .T0H       (3),
        .T1H       (7),
        .T_RST     (20)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .en        (en),
        .adr_b     (adr_b),
        .dat_b     (dat_b),
        .led_out   (led_out),
        .busy      (busy),
        .frame_done(frame_done)
    );

    everloop_driver dut_def (
        .clk       (clk),
        .resetn    (resetn2),
        .en        (en2),
        .adr_b     (adr2),
        .dat_b     (dat2),
        .led_out   (led2),
        .busy      (busy2),
        .frame_done(frame_done2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign dat2 = 16'h0000;

    always @(posedge clk) dat_b <= ram[adr_b];

    // Sample index 'cyc' labels each negedge; pulse edges and widths are logged
    always @(negedge clk) begin
        cyc      <= cyc + 1;
        led_prev <= led_out;
        if (led_out === 1'b1 && led_prev === 1'b0) begin
            rises.push_back(cyc);
            rise_t <= cyc;
        end
        if (led_out === 1'b0 && led_prev === 1'b1) widths.push_back(cyc - rise_t);
        if (frame_done === 1'b1) fd_count <= fd_count + 1;

        led2_prev <= led2;
        if (led2 === 1'b1 && led2_prev === 1'b0) begin
            rises2  <= rises2 + 1;
            rise2_t <= cyc;
        end
        if (led2 === 1'b0 && led2_prev === 1'b1 && (cyc - rise2_t) != 20) bad2 <= bad2 + 1;
        if (frame_done2 === 1'b1 && fd2_lbl == 0) fd2_lbl <= cyc;
        if (led2 === 1'b1 && fd2_lbl != 0) late2 <= late2 + 1;
        if (busy2 === 1'b0 && fd2_lbl != 0 && idle2_lbl == 0) idle2_lbl <= cyc;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic goto(input int lbl);
        while (cyc < lbl) @(negedge clk);
    endtask

    // 7-clock high = 1, 3-clock high = 0; anything else is counted as bad
    task automatic dec(input int base, output logic [15:0] w, output int bad);
        w   = '0;
        bad = 0;
        for (int i = 0; i < 16; i++) begin
            w = {w[14:0], (widths[base + i] == 7)};
            if (widths[base + i] != 7 && widths[base + i] != 3) bad++;
        end
    endtask

    initial begin
        int c0, c1, c2, c3, b0, b1, b2, b3, f0, bad, bad_tot;
        logic [15:0] w;

        for (int i = 0; i < 128; i++) ram[i] = 16'h0000;
        resetn  = 1'b0;
        resetn2 = 1'b0;
        en      = 1'b0;
        en2     = 1'b0;
        repeat (3) @(negedge clk);

        check("reset_led", {31'd0, led_out}, 32'd0);
        check("reset_adr", {25'd0, adr_b}, 32'd0);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_frame_done", {31'd0, frame_done}, 32'd0);
        resetn  = 1'b1;
        resetn2 = 1'b1;
        @(negedge clk);

        // Default-parameter instance: one all-zero frame runs in the background
        en2 = 1'b1;
        @(negedge clk);
        en2 = 1'b0;

        // Single frame from a one-clock enable pulse
        ram[0] = 16'hA5F0;
        ram[1] = 16'h0001;
        bad_tot = 0;
        b0 = rises.size();
        f0 = fd_count;
        c0 = cyc;
        en = 1'b1;
        goto(c0 + 1);
        en = 1'b0;
        goto(c0 + 10);
        check("s1_prefetch_adr_w1", {25'd0, adr_b}, 32'd1);
        goto(c0 + 170);
        check("s1_prefetch_adr_w2", {25'd0, adr_b}, 32'd2);
        goto(c0 + 323);
        check("s1_frame_done_hi", {31'd0, frame_done}, 32'd1);
        check("s1_busy_latch", {31'd0, busy}, 32'd1);
        check("s1_led_latch", {31'd0, led_out}, 32'd0);
        goto(c0 + 324);
        check("s1_frame_done_lo", {31'd0, frame_done}, 32'd0);
        goto(c0 + 342);
        check("s1_busy_last_latch", {31'd0, busy}, 32'd1);
        goto(c0 + 343);
        check("s1_busy_idle", {31'd0, busy}, 32'd0);
        goto(c0 + 360);
        check("s1_bit_count", rises.size() - b0, 32'd32);
        check("s1_latency", rises[b0] - c0, 32'd4);
        check("s1_word_gap", rises[b0 + 16] - rises[b0], 32'd160);
        check("s1_last_bit", rises[b0 + 31] - rises[b0], 32'd310);
        dec(b0, w, bad);
        bad_tot += bad;
        check("s1_word0", {16'd0, w}, 32'h0000A5F0);
        dec(b0 + 16, w, bad);
        bad_tot += bad;
        check("s1_word1", {16'd0, w}, 32'h00000001);
        check("s1_frame_done_count", fd_count - f0, 32'd1);
        check("s1_bad_widths", bad_tot, 32'd0);

        // Continuous enable, RAM[1] rewritten after its prefetch, enable dropped in frame 2
        bad_tot = 0;
        b1 = rises.size();
        f0 = fd_count;
        c1 = cyc;
        en = 1'b1;
        goto(c1 + 56);
        ram[1] = 16'hFFFF;
        goto(c1 + 398);
        en = 1'b0;
        goto(c1 + 684);
        check("s2_busy_last_latch", {31'd0, busy}, 32'd1);
        goto(c1 + 685);
        check("s2_busy_idle", {31'd0, busy}, 32'd0);
        goto(c1 + 720);
        check("s2_bit_count", rises.size() - b1, 32'd64);
        check("s2_latency", rises[b1] - c1, 32'd4);
        check("s2_word_gap", rises[b1 + 16] - rises[b1], 32'd160);
        check("s2_frame_period", rises[b1 + 32] - rises[b1], 32'd342);
        dec(b1, w, bad);
        bad_tot += bad;
        check("s2_f1_word0", {16'd0, w}, 32'h0000A5F0);
        dec(b1 + 16, w, bad);
        bad_tot += bad;
        check("s2_f1_word1_old", {16'd0, w}, 32'h00000001);
        dec(b1 + 32, w, bad);
        bad_tot += bad;
        check("s2_f2_word0", {16'd0, w}, 32'h0000A5F0);
        dec(b1 + 48, w, bad);
        bad_tot += bad;
        check("s2_f2_word1_new", {16'd0, w}, 32'h0000FFFF);
        check("s2_frame_done_count", fd_count - f0, 32'd2);
        check("s2_bad_widths", bad_tot, 32'd0);

        // Reset during word 1 while the line is high, then restart from word 0
        ram[1] = 16'h0001;
        b2 = rises.size();
        c2 = cyc;
        en = 1'b1;
        goto(c2 + 1);
        en = 1'b0;
        goto(c2 + 174);
        check("s3_led_before_reset", {31'd0, led_out}, 32'd1);
        check("s3_adr_before_reset", {25'd0, adr_b}, 32'd2);
        resetn = 1'b0;
        goto(c2 + 175);
        check("s3_reset_led", {31'd0, led_out}, 32'd0);
        check("s3_reset_adr", {25'd0, adr_b}, 32'd0);
        check("s3_reset_busy", {31'd0, busy}, 32'd0);
        resetn = 1'b1;
        goto(c2 + 200);
        check("s3_aborted_bits", rises.size() - b2, 32'd18);
        check("s3_idle_after_reset", {31'd0, busy}, 32'd0);

        ram[1] = 16'h3C0F;
        bad_tot = 0;
        b3 = rises.size();
        c3 = cyc;
        en = 1'b1;
        goto(c3 + 1);
        en = 1'b0;
        goto(c3 + 360);
        check("s3_restart_bits", rises.size() - b3, 32'd32);
        check("s3_restart_latency", rises[b3] - c3, 32'd4);
        dec(b3, w, bad);
        bad_tot += bad;
        check("s3_restart_word0", {16'd0, w}, 32'h0000A5F0);
        dec(b3 + 16, w, bad);
        bad_tot += bad;
        check("s3_restart_word1", {16'd0, w}, 32'h00003C0F);
        check("s3_bad_widths", bad_tot, 32'd0);

        // Default-parameter frame: 1120 zero bits, then the 15000-clock latch gap
        while (idle2_lbl == 0 && cyc < 90000) @(negedge clk);
        @(negedge clk);
        check("def_bit_count", rises2, 32'd1120);
        check("def_bad_widths", bad2, 32'd0);
        check("def_latch_len", idle2_lbl - fd2_lbl, 32'd15000);
        check("def_led_in_latch", late2, 32'd0);
        check("def_busy_idle", {31'd0, busy2}, 32'd0);
        check("def_adr_idle", {25'd0, adr2}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
